id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the five-stage pipeline. It captures decoded operands, immediate, register addresses and control bits from ID at each clock edge and presents them to EX: operand muxes, forwarding unit and ALU. It supports hold (stall), bubble insertion (flush) and an optional write-back bypass that keeps captured register operands coherent with the same-cycle WB write. A saturating counter records inserted bubbles for performance monitoring.

## Interface
- No parameters; all datapaths are 32 bits and register addresses are 5 bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; one clock domain.
- `stall`  in  1  hold all EX-side fields.
- `flush`  in  1  load a bubble; has priority over `stall`.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  32 each  PC, register-file read data, sign-extended immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5 each  source and destination register indices.
- `id_alu_op`  in  4  ALU operation code.
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch`, `id_jump`  in  1 each  control bits.
- `wb_reg_write`  in  1  WB stage writes the register file this cycle.
- `wb_rd_addr`  in  5  WB destination.
- `wb_write_data`  in  32  WB write value.
- `ex_*`  out  one registered copy of every `id_*` input above, same widths, including `ex_valid`.
- `bubble_cnt`  out  16  saturating count of bubbles loaded.

## Operation
- Each rising edge, exactly one of three actions applies, highest priority first:
  - **Flush** (`flush`=1): `ex_valid`, all control bits and `ex_alu_op` go to 0; all data and address fields go to 0. `bubble_cnt` increments by 1 and saturates at 16'hFFFF.
  - **Hold** (`stall`=1, `flush`=0): every `ex_*` field keeps its value, except the held-operand refresh under bypass.
  - **Load** (otherwise): every `ex_*` field takes its `id_*` value, with the bypass applied to `ex_rs1_data` and `ex_rs2_data`.
  - A load with `id_valid`=0 is a pass-through and does not count as a bubble.
- Bypass match for source n:
  - Conditions: `wb_reg_write`=1, `wb_rd_addr`≠0 and `wb_rd_addr`==`id_rsn_addr`.
  - On load with a match, `ex_rsn_data` takes `wb_write_data` instead of `id_rsn_data`.
- Held-operand refresh:
  - Condition: hold cycle with `ex_valid`=1, `wb_reg_write`=1, `wb_rd_addr`≠0 and `wb_rd_addr`==`ex_rsn_addr`.
  - Action: `ex_rsn_data` takes `wb_write_data`. No other field changes.
- Register x0 is never bypassed or refreshed.
- `ex_rs1_addr` and `ex_rs2_addr` are always the captured indices. The forwarding unit consumes them unchanged.
- No internal state beyond the output registers and `bubble_cnt`.

## Timing
- Latency: one cycle. `id_*` sampled at edge k appears on `ex_*` after edge k.
- All outputs are registered; no combinational path from any input to any output.
- Reset: all `ex_*` outputs go to 0 immediately on `rst` assertion, including `ex_valid`=0 (a bubble). `bubble_cnt` also resets to 0.
- Reset mid-stall discards the held instruction.
- First load occurs on the first rising edge after `rst` deasserts.
- Flush and stall in the same cycle: flush wins, and the bubble is counted.
- Consecutive stalls hold indefinitely; a refresh may occur on every stall cycle.
- WB bypass and refresh use the WB values sampled at the same edge.

## Configuration
- Macro: `ID_EX_WB_BYPASS_EN`.
- Defined: load bypass and held-operand refresh operate as described above.
- Undefined: `ex_rs1_data` and `ex_rs2_data` load `id_rs1_data` and `id_rs2_data` unmodified and are held unchanged during stall. `wb_reg_write`, `wb_rd_addr` and `wb_write_data` are ignored. The register file must then be write-first.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with non-zero `ex_*` → all outputs 0 before the next edge, `bubble_cnt`=0.
- **Load:** `id_pc`=0x100, `id_imm`=0xFFFFFFF0, `id_alu_src`=1, `id_valid`=1, no stall/flush → next cycle `ex_pc`=0x100, `ex_imm`=0xFFFFFFF0, `ex_alu_src`=1, `ex_valid`=1.
- **Flush over stall:** `flush`=1 and `stall`=1 together → `ex_valid`=0, `ex_reg_write`=0, `ex_mem_write`=0, `bubble_cnt` increments by 1.
- **Load bypass** (macro defined): `id_rs2_addr`=5, `id_rs2_data`=0x11, WB writes x5=0xAA → `ex_rs2_data`=0xAA.
  - Same with `wb_rd_addr`=0 → `ex_rs2_data`=0x11.
- **Stall refresh** (macro defined): hold three cycles with `ex_rs1_addr`=7; WB writes x7=0x1234 in cycle 2 → `ex_rs1_data`=0x1234 from cycle 3; `ex_pc` unchanged throughout.
  - Macro undefined → old value retained.
- **Saturation:** apply 65 540 consecutive flushes → `bubble_cnt`=0xFFFF and stays there.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded ID fields into EX with hold,
// bubble insertion and a saturating bubble counter.
// Optional feature macro: ID_EX_WB_BYPASS_EN enables the WB load bypass and
// the refresh of held operands from the same-cycle WB write.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_write_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic [4:0]  ex_rd_addr,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [15:0] bubble_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RADDRW = 5;
  localparam int unsigned OPW    = 4;
  localparam int unsigned CNTW   = 16;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [RADDRW-1:0] rs1_addr;
    logic [RADDRW-1:0] rs2_addr;
    logic [RADDRW-1:0] rd_addr;
    logic [OPW-1:0]    alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
  } ex_fields_t;

  ex_fields_t        fields_q, fields_d;
  ex_fields_t        id_fields;
  logic [CNTW-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [XLEN-1:0]   ld_rs1_data, ld_rs2_data;
  logic [XLEN-1:0]   hold_rs1_data, hold_rs2_data;

  // Gather the ID-side fields into one payload
  always_comb begin
    id_fields            = '0;
    id_fields.valid      = id_valid;
    id_fields.pc         = id_pc;
    id_fields.rs1_data   = id_rs1_data;
    id_fields.rs2_data   = id_rs2_data;
    id_fields.imm        = id_imm;
    id_fields.rs1_addr   = id_rs1_addr;
    id_fields.rs2_addr   = id_rs2_addr;
    id_fields.rd_addr    = id_rd_addr;
    id_fields.alu_op     = id_alu_op;
    id_fields.alu_src    = id_alu_src;
    id_fields.mem_read   = id_mem_read;
    id_fields.mem_write  = id_mem_write;
    id_fields.reg_write  = id_reg_write;
    id_fields.mem_to_reg = id_mem_to_reg;
    id_fields.branch     = id_branch;
    id_fields.jump       = id_jump;
  end

`ifdef ID_EX_WB_BYPASS_EN
  logic wb_hit_c;
  assign wb_hit_c = wb_reg_write && (wb_rd_addr != RADDRW'(0));

  // Operand selection: WB value wins on an address match, x0 excluded
  always_comb begin
    ld_rs1_data   = id_rs1_data;
    ld_rs2_data   = id_rs2_data;
    hold_rs1_data = fields_q.rs1_data;
    hold_rs2_data = fields_q.rs2_data;
    if (wb_hit_c && (wb_rd_addr == id_rs1_addr)) ld_rs1_data = wb_write_data;
    if (wb_hit_c && (wb_rd_addr == id_rs2_addr)) ld_rs2_data = wb_write_data;
    if (fields_q.valid && wb_hit_c && (wb_rd_addr == fields_q.rs1_addr))
      hold_rs1_data = wb_write_data;
    if (fields_q.valid && wb_hit_c && (wb_rd_addr == fields_q.rs2_addr))
      hold_rs2_data = wb_write_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd_addr, wb_write_data};

  // Operand selection: register-file read data passes through unmodified
  always_comb begin
    ld_rs1_data   = id_rs1_data;
    ld_rs2_data   = id_rs2_data;
    hold_rs1_data = fields_q.rs1_data;
    hold_rs2_data = fields_q.rs2_data;
  end
`endif

  // Next-state: flush beats stall beats load; bubbles counted with saturation
  always_comb begin
    fields_d     = fields_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      fields_d = '0;
      if (bubble_cnt_q != {CNTW{1'b1}}) bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end else if (stall) begin
      fields_d.rs1_data = hold_rs1_data;
      fields_d.rs2_data = hold_rs2_data;
    end else begin
      fields_d          = id_fields;
      fields_d.rs1_data = ld_rs1_data;
      fields_d.rs2_data = ld_rs2_data;
    end
  end

  // Pipeline register and bubble counter; reset loads a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fields_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fields_q     <= fields_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = fields_q.valid;
  assign ex_pc         = fields_q.pc;
  assign ex_rs1_data   = fields_q.rs1_data;
  assign ex_rs2_data   = fields_q.rs2_data;
  assign ex_imm        = fields_q.imm;
  assign ex_rs1_addr   = fields_q.rs1_addr;
  assign ex_rs2_addr   = fields_q.rs2_addr;
  assign ex_rd_addr    = fields_q.rd_addr;
  assign ex_alu_op     = fields_q.alu_op;
  assign ex_alu_src    = fields_q.alu_src;
  assign ex_mem_read   = fields_q.mem_read;
  assign ex_mem_write  = fields_q.mem_write;
  assign ex_reg_write  = fields_q.reg_write;
  assign ex_mem_to_reg = fields_q.mem_to_reg;
  assign ex_branch     = fields_q.branch;
  assign ex_jump       = fields_q.jump;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: vector table plus reset and saturation sequences.
// Expectations follow ID_EX_WB_BYPASS_EN when it is defined for the build.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic        id_mem_to_reg, id_branch, id_jump;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_write_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_jump;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .id_jump(id_jump), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // ctrl bit order: alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  op;
    logic [6:0]  ctrl;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        ev;
    logic [31:0] epc, eimm, e1b, e1n, e2b, e2n;
    logic [4:0]  e1a, e2a, erd;
    logic [3:0]  eop;
    logic [6:0]  ectrl;
    logic [15:0] ecnt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; id_valid = v.valid;
    id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
    id_rs1_addr = v.rs1a; id_rs2_addr = v.rs2a; id_rd_addr = v.rd;
    id_alu_op = v.op;
    {id_alu_src, id_mem_read, id_mem_write, id_reg_write,
     id_mem_to_reg, id_branch, id_jump} = v.ctrl;
    wb_reg_write = v.wbwe; wb_rd_addr = v.wbrd; wb_write_data = v.wbd;
  endtask

  function automatic logic [6:0] ex_ctrl();
    return {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
            ex_mem_to_reg, ex_branch, ex_jump};
  endfunction

  function automatic logic all_zero();
    return ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr,
             ex_rs2_addr, ex_rd_addr, ex_alu_op, ex_ctrl(), bubble_cnt} == '0);
  endfunction

  initial begin
    vec_t v;
    logic [31:0] e1, e2;
    // stall flush valid pc rs1d rs2d imm rs1a rs2a rd op ctrl wbwe wbrd wbd |
    // ev epc eimm e1b e1n e2b e2n e1a e2a erd eop ectrl ecnt
    vecs[0]  = '{1'b0,1'b0,1'b1,32'h100,32'hA1,32'hB2,32'hFFFFFFF0,5'd1,5'd2,5'd9,4'd3,7'h40,1'b0,5'd0,32'h0,
                 1'b1,32'h100,32'hFFFFFFF0,32'hA1,32'hA1,32'hB2,32'hB2,5'd1,5'd2,5'd9,4'd3,7'h40,16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'h104,32'h33,32'h11,32'h8,5'd3,5'd5,5'd6,4'd2,7'h08,1'b1,5'd5,32'hAA,
                 1'b1,32'h104,32'h8,32'h33,32'h33,32'hAA,32'h11,5'd3,5'd5,5'd6,4'd2,7'h08,16'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,32'h108,32'h44,32'h11,32'hC,5'd4,5'd0,5'd7,4'd1,7'h02,1'b1,5'd0,32'hAA,
                 1'b1,32'h108,32'hC,32'h44,32'h44,32'h11,32'h11,5'd4,5'd0,5'd7,4'd1,7'h02,16'd0};
    vecs[3]  = '{1'b1,1'b1,1'b1,32'h10C,32'h55,32'h66,32'h10,5'd1,5'd2,5'd3,4'd4,7'h18,1'b1,5'd1,32'h77,
                 1'b0,32'h0,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,4'd0,7'h00,16'd1};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h200,32'h55,32'h66,32'h0,5'd7,5'd8,5'd0,4'd0,7'h00,1'b1,5'd7,32'h77,
                 1'b0,32'h200,32'h0,32'h77,32'h55,32'h66,32'h66,5'd7,5'd8,5'd0,4'd0,7'h00,16'd1};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'h300,32'h1000,32'h2000,32'h4,5'd7,5'd7,5'd10,4'd5,7'h24,1'b0,5'd0,32'h0,
                 1'b1,32'h300,32'h4,32'h1000,32'h1000,32'h2000,32'h2000,5'd7,5'd7,5'd10,4'd5,7'h24,16'd1};
    vecs[6]  = '{1'b1,1'b0,1'b1,32'h400,32'hBAD,32'hBAD,32'h99,5'd1,5'd1,5'd1,4'hF,7'h7F,1'b0,5'd7,32'h5555,
                 1'b1,32'h300,32'h4,32'h1000,32'h1000,32'h2000,32'h2000,5'd7,5'd7,5'd10,4'd5,7'h24,16'd1};
    vecs[7]  = '{1'b1,1'b0,1'b1,32'h400,32'hBAD,32'hBAD,32'h99,5'd1,5'd1,5'd1,4'hF,7'h7F,1'b1,5'd7,32'h1234,
                 1'b1,32'h300,32'h4,32'h1234,32'h1000,32'h1234,32'h2000,5'd7,5'd7,5'd10,4'd5,7'h24,16'd1};
    vecs[8]  = '{1'b1,1'b0,1'b1,32'h400,32'hBAD,32'hBAD,32'h99,5'd1,5'd1,5'd1,4'hF,7'h7F,1'b1,5'd0,32'hFFFF,
                 1'b1,32'h300,32'h4,32'h1234,32'h1000,32'h1234,32'h2000,5'd7,5'd7,5'd10,4'd5,7'h24,16'd1};
    vecs[9]  = '{1'b0,1'b1,1'b1,32'h404,32'h1,32'h2,32'h3,5'd7,5'd7,5'd7,4'd7,7'h7F,1'b1,5'd7,32'hAAAA,
                 1'b0,32'h0,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,4'd0,7'h00,16'd2};
    vecs[10] = '{1'b0,1'b0,1'b1,32'h500,32'h10,32'h20,32'h14,5'd3,5'd3,5'd1,4'd6,7'h01,1'b1,5'd3,32'hDEAD,
                 1'b1,32'h500,32'h14,32'hDEAD,32'h10,32'hDEAD,32'h20,5'd3,5'd3,5'd1,4'd6,7'h01,16'd2};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h600,32'h1,32'h2,32'h0,5'd9,5'd0,5'd0,4'd0,7'h00,1'b0,5'd0,32'h0,
                 1'b0,32'h600,32'h0,32'h1,32'h1,32'h2,32'h2,5'd9,5'd0,5'd0,4'd0,7'h00,16'd2};
    vecs[12] = '{1'b1,1'b0,1'b1,32'h700,32'h5,32'h6,32'h7,5'd9,5'd9,5'd9,4'd9,7'h7F,1'b1,5'd9,32'hCAFE,
                 1'b0,32'h600,32'h0,32'h1,32'h1,32'h2,32'h2,5'd9,5'd0,5'd0,4'd0,7'h00,16'd2};

    // reset state
    drive(vecs[11]);
    rst = 1'b1;
    #12;
    chk("reset_zero", 32'(all_zero()), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      @(posedge clk);
      #1;
`ifdef ID_EX_WB_BYPASS_EN
      e1 = v.e1b; e2 = v.e2b;
`else
      e1 = v.e1n; e2 = v.e2n;
`endif
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(v.ev));
      chk($sformatf("v%0d_pc", i), ex_pc, v.epc);
      chk($sformatf("v%0d_imm", i), ex_imm, v.eimm);
      chk($sformatf("v%0d_rs1_data", i), ex_rs1_data, e1);
      chk($sformatf("v%0d_rs2_data", i), ex_rs2_data, e2);
      chk($sformatf("v%0d_addrs", i), 32'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}),
          32'({v.e1a, v.e2a, v.erd}));
      chk($sformatf("v%0d_ctrl", i), 32'({ex_alu_op, ex_ctrl()}), 32'({v.eop, v.ectrl}));
      chk($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(v.ecnt));
      @(negedge clk);
    end

    // load a live instruction, then async reset mid-cycle while stalled
    drive(vecs[10]);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_live", 32'(ex_valid), 32'd1);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_zero", 32'(all_zero()), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("first_load_pc", ex_pc, 32'h100);
    chk("first_load_imm", ex_imm, 32'hFFFFFFF0);
    chk("first_load_alu_src", 32'(ex_alu_src), 32'd1);
    chk("first_load_valid", 32'(ex_valid), 32'd1);
    chk("first_load_cnt", 32'(bubble_cnt), 32'd0);

    // bubble counter saturation
    @(negedge clk);
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("cnt_pre_sat", 32'(bubble_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("cnt_sat", 32'(bubble_cnt), 32'hFFFF);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    chk("cnt_stay_sat", 32'(bubble_cnt), 32'hFFFF);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(vecs[1]);
    @(posedge clk);
    #1;
    chk("cnt_after_load", 32'(bubble_cnt), 32'hFFFF);
    chk("load_after_sat_pc", ex_pc, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
